// File: rtl/rocket_pool_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rocket_pool_if
// Description : Bundle of the frame, fire-request, collision and per-slot
//               position signals exchanged between the game layer and
//               rocket_pool_controller.
//   master : drives startOfFrame, fireReq, fireX/Y, fireSpeedX/Y, collision;
//            receives fireAck, fireSlot, fireDrop, activeMask, topLeftX/Y
//   slave  : the rocket_pool_controller side (directions mirrored)
// Revision    : 1.0 - initial release
// ============================================================================
interface rocket_pool_if #(
    parameter int NUM_ROCKETS = 4,
    parameter int COORD_W     = 11,
    parameter int SPEED_W     = 9
);
    localparam int C_SLOT_W = (NUM_ROCKETS > 1) ? $clog2(NUM_ROCKETS) : 1;

    logic                             startOfFrame;
    logic                             fireReq;
    logic signed [COORD_W-1:0]        fireX;
    logic signed [COORD_W-1:0]        fireY;
    logic signed [SPEED_W-1:0]        fireSpeedX;
    logic signed [SPEED_W-1:0]        fireSpeedY;
    logic [NUM_ROCKETS-1:0]           collision;
    logic                             fireAck;
    logic [C_SLOT_W-1:0]              fireSlot;
    logic                             fireDrop;
    logic [NUM_ROCKETS-1:0]           activeMask;
    logic [NUM_ROCKETS*COORD_W-1:0]   topLeftX;
    logic [NUM_ROCKETS*COORD_W-1:0]   topLeftY;

    modport master (
        output startOfFrame, fireReq, fireX, fireY, fireSpeedX, fireSpeedY, collision,
        input  fireAck, fireSlot, fireDrop, activeMask, topLeftX, topLeftY
    );

    modport slave (
        input  startOfFrame, fireReq, fireX, fireY, fireSpeedX, fireSpeedY, collision,
        output fireAck, fireSlot, fireDrop, activeMask, topLeftX, topLeftY
    );
endinterface
`default_nettype wire

// File: rtl/rocket_pool_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rocket_pool_controller
// Description : Pool of NUM_ROCKETS projectiles. Grants the lowest idle slot
//               on each fire request (subject to a frame-based reload
//               cooldown), integrates fixed-point X/Y motion once per frame
//               and retires slots on collision or on leaving the window.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : rocket_pool_if slave port (fire request/response, frame pulse,
//            collision mask, activity mask, packed per-slot positions)
// Revision    : 1.0 - initial release
// ============================================================================
module rocket_pool_controller #(
    parameter int NUM_ROCKETS   = 4,
    parameter int FRAC_BITS     = 6,
    parameter int COORD_W       = 11,
    parameter int SPEED_W       = 9,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int RELOAD_FRAMES = 8
) (
    input  logic            clk,
    input  logic            resetN,
    rocket_pool_if.slave    bus
);
    // Two guard bits above the integer part keep an out-of-window step from
    // wrapping back into the window before the slot retires.
    localparam int C_ACC_W  = COORD_W + FRAC_BITS + 2;
    localparam int C_SLOT_W = (NUM_ROCKETS > 1) ? $clog2(NUM_ROCKETS) : 1;
    localparam int C_CD_W   = (RELOAD_FRAMES > 0) ? $clog2(RELOAD_FRAMES + 1) : 1;

    localparam logic signed [C_ACC_W-1:0] C_X_LO = C_ACC_W'(X_MIN * (2 ** FRAC_BITS));
    localparam logic signed [C_ACC_W-1:0] C_X_HI = C_ACC_W'(X_MAX * (2 ** FRAC_BITS));
    localparam logic signed [C_ACC_W-1:0] C_Y_LO = C_ACC_W'(Y_MIN * (2 ** FRAC_BITS));
    localparam logic signed [C_ACC_W-1:0] C_Y_HI = C_ACC_W'(Y_MAX * (2 ** FRAC_BITS));

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_FLYING = 1'b1
    } slot_state_t;

    slot_state_t                 state_q [NUM_ROCKETS];
    slot_state_t                 state_d [NUM_ROCKETS];
    logic signed [C_ACC_W-1:0]   acc_x_q [NUM_ROCKETS];
    logic signed [C_ACC_W-1:0]   acc_x_d [NUM_ROCKETS];
    logic signed [C_ACC_W-1:0]   acc_y_q [NUM_ROCKETS];
    logic signed [C_ACC_W-1:0]   acc_y_d [NUM_ROCKETS];
    logic signed [SPEED_W-1:0]   spd_x_q [NUM_ROCKETS];
    logic signed [SPEED_W-1:0]   spd_x_d [NUM_ROCKETS];
    logic signed [SPEED_W-1:0]   spd_y_q [NUM_ROCKETS];
    logic signed [SPEED_W-1:0]   spd_y_d [NUM_ROCKETS];
    logic [COORD_W-1:0]          pos_x_q [NUM_ROCKETS];
    logic [COORD_W-1:0]          pos_x_d [NUM_ROCKETS];
    logic [COORD_W-1:0]          pos_y_q [NUM_ROCKETS];
    logic [COORD_W-1:0]          pos_y_d [NUM_ROCKETS];

    logic [C_CD_W-1:0]           cooldown_q;
    logic [C_CD_W-1:0]           cooldown_d;
    logic                        fire_ack_q;
    logic                        fire_ack_d;
    logic                        fire_drop_q;
    logic                        fire_drop_d;
    logic [C_SLOT_W-1:0]         fire_slot_q;
    logic [C_SLOT_W-1:0]         fire_slot_d;

    logic                        w_alloc_found;
    logic [C_SLOT_W-1:0]         w_alloc_idx;
    logic                        w_accept;
    logic [NUM_ROCKETS-1:0]      w_out_of_win;
    logic signed [C_ACC_W-1:0]   w_load_x;
    logic signed [C_ACC_W-1:0]   w_load_y;

    // ------------------------------------------------------------------------
    // Allocation: lowest-index idle slot, judged on pre-edge state so a slot
    // retiring at this edge is still seen as busy.
    // ------------------------------------------------------------------------
    always_comb begin
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            if (!w_alloc_found && (state_q[i] == S_IDLE)) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = C_SLOT_W'(i);
            end
        end
        w_accept = bus.fireReq && (cooldown_q == '0) && w_alloc_found;
        w_load_x = {{(C_ACC_W-COORD_W){bus.fireX[COORD_W-1]}}, bus.fireX} << FRAC_BITS;
        w_load_y = {{(C_ACC_W-COORD_W){bus.fireY[COORD_W-1]}}, bus.fireY} << FRAC_BITS;
    end

    // Window check on the registered accumulator; the retire happens one edge
    // after the out-of-window position was stored.
    always_comb begin
        w_out_of_win = '0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            w_out_of_win[i] = (acc_x_q[i] < C_X_LO) || (acc_x_q[i] > C_X_HI) ||
                              (acc_y_q[i] < C_Y_LO) || (acc_y_q[i] > C_Y_HI);
        end
    end

    // ------------------------------------------------------------------------
    // Per-slot next state, motion and load
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            state_d[i] = state_q[i];
            acc_x_d[i] = acc_x_q[i];
            acc_y_d[i] = acc_y_q[i];
            spd_x_d[i] = spd_x_q[i];
            spd_y_d[i] = spd_y_q[i];
            pos_x_d[i] = acc_x_q[i][FRAC_BITS +: COORD_W];
            pos_y_d[i] = acc_y_q[i][FRAC_BITS +: COORD_W];

            case (state_q[i])
                S_FLYING: begin
                    // Retiring slots freeze: collision beats a coincident frame.
                    if (bus.collision[i] || w_out_of_win[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (bus.startOfFrame) begin
                        acc_x_d[i] = acc_x_q[i] +
                            {{(C_ACC_W-SPEED_W){spd_x_q[i][SPEED_W-1]}}, spd_x_q[i]};
                        acc_y_d[i] = acc_y_q[i] +
                            {{(C_ACC_W-SPEED_W){spd_y_q[i][SPEED_W-1]}}, spd_y_q[i]};
                    end
                end
                default: begin
                    if (w_accept && (w_alloc_idx == C_SLOT_W'(i))) begin
                        state_d[i] = S_FLYING;
                        acc_x_d[i] = w_load_x;
                        acc_y_d[i] = w_load_y;
                        spd_x_d[i] = bus.fireSpeedX;
                        spd_y_d[i] = bus.fireSpeedY;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Cooldown and fire response
    // ------------------------------------------------------------------------
    always_comb begin
        cooldown_d = cooldown_q;
        if (w_accept) begin
            cooldown_d = C_CD_W'(RELOAD_FRAMES);
        end else if (bus.startOfFrame && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - C_CD_W'(1);
        end
        fire_ack_d  = w_accept;
        fire_drop_d = bus.fireReq && !w_accept;
        fire_slot_d = w_accept ? w_alloc_idx : fire_slot_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_ROCKETS; i++) begin
                state_q[i] <= S_IDLE;
                acc_x_q[i] <= '0;
                acc_y_q[i] <= '0;
                spd_x_q[i] <= '0;
                spd_y_q[i] <= '0;
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
            end
            cooldown_q  <= '0;
            fire_ack_q  <= 1'b0;
            fire_drop_q <= 1'b0;
            fire_slot_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ROCKETS; i++) begin
                state_q[i] <= state_d[i];
                acc_x_q[i] <= acc_x_d[i];
                acc_y_q[i] <= acc_y_d[i];
                spd_x_q[i] <= spd_x_d[i];
                spd_y_q[i] <= spd_y_d[i];
                pos_x_q[i] <= pos_x_d[i];
                pos_y_q[i] <= pos_y_d[i];
            end
            cooldown_q  <= cooldown_d;
            fire_ack_q  <= fire_ack_d;
            fire_drop_q <= fire_drop_d;
            fire_slot_q <= fire_slot_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.fireAck  = fire_ack_q;
    assign bus.fireDrop = fire_drop_q;
    assign bus.fireSlot = fire_slot_q;

    generate
        for (genvar g = 0; g < NUM_ROCKETS; g++) begin : g_slot_out
            assign bus.activeMask[g]                     = (state_q[g] == S_FLYING);
            assign bus.topLeftX[g*COORD_W +: COORD_W]    = pos_x_q[g];
            assign bus.topLeftY[g*COORD_W +: COORD_W]    = pos_y_q[g];
        end
    endgenerate

endmodule
`default_nettype wire
